// File: rtl/vdp_video_out_ctrl_pkg.sv
// Shared types and constants for the video-out register controller.
// Holds the controller state encoding, reset values and the saturating quotient helper.
`timescale 1ns/1ps
package vdp_video_out_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DIV        = 2'd1,
    ST_WAIT_FRAME = 2'd2
  } ctrl_state_e;

  localparam logic [7:0] DEFAULT_DENOMINATOR = 8'd200;
  localparam logic [7:0] DEFAULT_NORMALIZE   = 8'd41;
  localparam int         NORM_NUMERATOR      = 8192;
  localparam int         H_TOTAL             = 2736;
  localparam int         DIV_STEPS           = 14;
  localparam logic [7:0] NORM_SAT            = 8'hFF;

  // Quotients that do not fit the 8-bit normalize register clamp to full scale.
  function automatic logic [7:0] sat_norm(input logic [13:0] q);
    return (q > 14'd255) ? NORM_SAT : q[7:0];
  endfunction

endpackage

// File: rtl/vdp_norm_divider.sv
// Restoring divider producing round(NORM_NUMERATOR / den), one quotient bit per clock.
// A start pulse loads the operands; done is high during the final iteration.
`timescale 1ns/1ps
module vdp_norm_divider
  import vdp_video_out_ctrl_pkg::*;
#(
  parameter int NORM_NUMERATOR = vdp_video_out_ctrl_pkg::NORM_NUMERATOR
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] den,
  output logic       done,
  output logic [7:0] quotient
);

  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  den_q, den_d;
  logic [13:0] qsh_q, qsh_d;
  logic [8:0]  trial;
  logic        fits;

  // Adding den/2 to the numerator turns the truncating divide into round-to-nearest.
  function automatic logic [13:0] dividend(input logic [7:0] d);
    return 14'(NORM_NUMERATOR) + ({6'd0, d} >> 1);
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    den_d = den_q;
    qsh_d = qsh_q;
    trial = {rem_q, qsh_q[13]};
    fits  = (trial >= {1'b0, den_q});
    if (start) begin
      den_d = den;
      qsh_d = dividend(den);
      rem_d = '0;
      cnt_d = 4'(DIV_STEPS);
    end else if (cnt_q != 4'd0) begin
      // Dividend bits shift out the top while quotient bits shift in at the bottom.
      rem_d = fits ? 8'(trial - {1'b0, den_q}) : trial[7:0];
      qsh_d = {qsh_q[12:0], fits};
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      qsh_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      den_q <= den_d;
      qsh_q <= qsh_d;
    end
  end

  assign done     = (cnt_q == 4'd1);
  assign quotient = sat_norm(qsh_q);

endmodule

// File: rtl/vdp_video_out_ctrl.sv
// Frame-synchronous commit of the denominator/normalize pair for vdp_video_out.
// Define VDP_VIDEO_OUT_CTRL_SCANLINE_EN to build in the scanline strobe generator.
`timescale 1ns/1ps
module vdp_video_out_ctrl
  import vdp_video_out_ctrl_pkg::*;
#(
  parameter int H_TOTAL        = vdp_video_out_ctrl_pkg::H_TOTAL,
  parameter int NORM_NUMERATOR = vdp_video_out_ctrl_pkg::NORM_NUMERATOR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] h_count,
  input  logic [9:0]  v_count,
  input  logic        wr_req,
  input  logic [7:0]  wr_denominator,
  output logic        wr_ack,
  output logic        busy,
  output logic [7:0]  reg_denominator,
  output logic [7:0]  reg_normalize,
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
  input  logic        scanline_en,
`endif
  output logic        has_scanline
);

  // h_count is 12 bits wide, so a longer line could never reach its origin reliably.
  if (H_TOTAL < 1 || H_TOTAL > 4096) begin : g_h_total_check
    $error("H_TOTAL does not fit the 12-bit h_count");
  end

  ctrl_state_e state_q, state_d;
  logic        busy_q, busy_d;
  logic        wr_ack_q, wr_ack_d;
  logic [7:0]  reg_den_q, reg_den_d;
  logic [7:0]  reg_norm_q, reg_norm_d;
  logic [7:0]  pend_den_q, pend_den_d;
  logic        frame_start;
  logic        div_start;
  logic        div_done;
  logic [7:0]  div_quotient;

  assign frame_start = (h_count == 12'd0) && (v_count == 10'd0);
  // A zero denominator never enters the divider; its result is known to be saturated.
  assign div_start   = (state_q == ST_IDLE) && wr_req && (wr_denominator != 8'd0);

  vdp_norm_divider #(
    .NORM_NUMERATOR(NORM_NUMERATOR)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .den      (wr_denominator),
    .done     (div_done),
    .quotient (div_quotient)
  );

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    wr_ack_d   = 1'b0;
    reg_den_d  = reg_den_q;
    reg_norm_d = reg_norm_q;
    pend_den_d = pend_den_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_req) begin
          pend_den_d = wr_denominator;
          busy_d     = 1'b1;
          state_d    = (wr_denominator == 8'd0) ? ST_WAIT_FRAME : ST_DIV;
        end
      end
      ST_DIV: begin
        // A frame start during the last iteration is missed on purpose; the result is not ready.
        if (div_done) state_d = ST_WAIT_FRAME;
      end
      ST_WAIT_FRAME: begin
        if (frame_start) begin
          reg_den_d  = pend_den_q;
          reg_norm_d = (pend_den_q == 8'd0) ? NORM_SAT : div_quotient;
          wr_ack_d   = 1'b1;
          busy_d     = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      wr_ack_q   <= 1'b0;
      reg_den_q  <= DEFAULT_DENOMINATOR;
      reg_norm_q <= DEFAULT_NORMALIZE;
      pend_den_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      wr_ack_q   <= wr_ack_d;
      reg_den_q  <= reg_den_d;
      reg_norm_q <= reg_norm_d;
      pend_den_q <= pend_den_d;
    end
  end

  assign busy            = busy_q;
  assign wr_ack          = wr_ack_q;
  assign reg_denominator = reg_den_q;
  assign reg_normalize   = reg_norm_q;

`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
  logic scan_en_q, scan_en_d;
  logic has_scan_q, has_scan_d;

  // The enable only takes effect at a frame boundary so a frame is never half-striped.
  always_comb begin
    scan_en_d  = frame_start ? scanline_en : scan_en_q;
    has_scan_d = scan_en_q & v_count[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_en_q  <= 1'b0;
      has_scan_q <= 1'b0;
    end else begin
      scan_en_q  <= scan_en_d;
      has_scan_q <= has_scan_d;
    end
  end

  assign has_scanline = has_scan_q;
`else
  assign has_scanline = 1'b0;
`endif

endmodule

// File: tb/tb_vdp_video_out_ctrl.sv
// Scoreboard bench for vdp_video_out_ctrl: directed cases followed by random writes and resets.
// Expected commits come from a latency/arithmetic model; a monitor compares every cycle.
`timescale 1ns/1ps
module tb_vdp_video_out_ctrl;

  // The controller only keys on the raster origin, so a short raster keeps runs brief.
  localparam int H_LEN = 40;
  localparam int V_LEN = 4;
  localparam int FRAME = H_LEN * V_LEN;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] h_count = '0;
  logic [9:0]  v_count = '0;
  logic        wr_req = 1'b0;
  logic [7:0]  wr_denominator = '0;
  logic        wr_ack;
  logic        busy;
  logic [7:0]  reg_denominator;
  logic [7:0]  reg_normalize;
  logic        has_scanline;
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
  logic        scanline_en = 1'b0;
`endif

  vdp_video_out_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .h_count         (h_count),
    .v_count         (v_count),
    .wr_req          (wr_req),
    .wr_denominator  (wr_denominator),
    .wr_ack          (wr_ack),
    .busy            (busy),
    .reg_denominator (reg_denominator),
    .reg_normalize   (reg_normalize),
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
    .scanline_en     (scanline_en),
`endif
    .has_scanline    (has_scanline)
  );

  always #6 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] ref_norm(input int d);
    int q;
    if (d == 0) return 8'd255;
    q = (8192 + d / 2) / d;
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  // Raster generator: advances on the falling edge so it is stable at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (h_count == 12'(H_LEN - 1)) begin
        h_count = '0;
        v_count = (v_count == 10'(V_LEN - 1)) ? '0 : v_count + 10'd1;
      end else begin
        h_count = h_count + 12'd1;
      end
    end
  end

  // Reference model, evaluated on each rising edge from the inputs the DUT sees there.
  typedef struct {
    logic [7:0] den;
    logic [7:0] norm;
  } commit_t;
  commit_t     exp_q[$];
  bit          m_pend = 1'b0;
  bit          m_ack = 1'b0;
  bit          m_scan = 1'b0;
  int          m_ready = 0;
  logic [7:0]  m_den = 8'd200;
  logic [7:0]  m_norm = 8'd41;
  logic [7:0]  p_den = '0;
  logic [7:0]  p_norm = '0;
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
  bit          m_scan_en = 1'b0;
`endif

  always @(posedge clk) begin
    bit frame;
    cyc++;
    m_ack = 1'b0;
    frame = (h_count == 12'd0) && (v_count == 10'd0);
    if (reset) begin
      m_pend = 1'b0;
      m_den  = 8'd200;
      m_norm = 8'd41;
      m_scan = 1'b0;
      exp_q.delete();
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
      m_scan_en = 1'b0;
`endif
    end else begin
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
      m_scan = m_scan_en && v_count[0];
      if (frame) m_scan_en = scanline_en;
`endif
      if (m_pend) begin
        if (cyc >= m_ready && frame) begin
          m_pend = 1'b0;
          m_ack  = 1'b1;
          m_den  = p_den;
          m_norm = p_norm;
        end
      end else if (wr_req) begin
        m_pend  = 1'b1;
        p_den   = wr_denominator;
        p_norm  = ref_norm(int'(wr_denominator));
        // Zero skips the 14 divide cycles; otherwise accept + 14 iterations precede commit.
        m_ready = cyc + ((wr_denominator == 8'd0) ? 1 : 15);
        exp_q.push_back('{den: wr_denominator, norm: p_norm});
      end
    end
  end

  // Monitor: compares outputs shortly after every rising edge and pops on each wr_ack.
  initial begin
    commit_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("reg_denominator", 32'(reg_denominator), 32'(m_den));
      chk("reg_normalize", 32'(reg_normalize), 32'(m_norm));
      chk("busy", 32'(busy), 32'(m_pend));
      chk("wr_ack", 32'(wr_ack), 32'(m_ack));
      chk("has_scanline", 32'(has_scanline), 32'(m_scan));
      if (wr_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_ack: got ack with 0 entries expected >=1 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_denominator", 32'(reg_denominator), 32'(e.den));
          chk("sb_normalize", 32'(reg_normalize), 32'(e.norm));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write_den(input logic [7:0] d);
    step();
    wr_req = 1'b1;
    wr_denominator = d;
    step();
    wr_req = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (m_pend && n < max_cyc) begin
      step();
      n++;
    end
    chk("commit_timeout", 32'(m_pend), 32'd0);
  endtask

  localparam int NDIR = 6;
  logic [7:0] dir_den  [NDIR] = '{8'd100, 8'd200, 8'd255, 8'd33, 8'd32, 8'd0};
  logic [7:0] dir_norm [NDIR] = '{8'd82, 8'd41, 8'd32, 8'd248, 8'd255, 8'd255};

  initial begin
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    chk("rst_denominator", 32'(reg_denominator), 32'd200);
    chk("rst_normalize", 32'(reg_normalize), 32'd41);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_has_scanline", 32'(has_scanline), 32'd0);

    for (int i = 0; i < NDIR; i++) begin
      write_den(dir_den[i]);
      wait_idle(3 * FRAME);
      chk("dir_denominator", 32'(reg_denominator), 32'(dir_den[i]));
      chk("dir_normalize", 32'(reg_normalize), 32'(dir_norm[i]));
    end

    // Second request three clocks after the first lands while busy and must vanish.
    write_den(8'd100);
    step();
    step();
    write_den(8'd50);
    wait_idle(3 * FRAME);
    chk("dbl_denominator", 32'(reg_denominator), 32'd100);
    chk("dbl_normalize", 32'(reg_normalize), 32'd82);
    step();
    chk("dbl_queue_empty", 32'(exp_q.size()), 32'd0);

    // Frame start during the final divide iteration must defer commit a whole frame.
    for (int n = 0; n <= FRAME && (int'(v_count) * H_LEN + int'(h_count)) != FRAME - 14; n++)
      step();
    wr_req = 1'b1;
    wr_denominator = 8'd255;
    step();
    wr_req = 1'b0;
    repeat (20) step();
    chk("late_frame_busy", 32'(busy), 32'd1);
    wait_idle(3 * FRAME);
    chk("late_frame_normalize", 32'(reg_normalize), 32'd32);

    // Reset five clocks into the divide discards the request immediately.
    write_den(8'd33);
    repeat (5) step();
    reset = 1'b1;
    #1;
    chk("midrst_denominator", 32'(reg_denominator), 32'd200);
    chk("midrst_normalize", 32'(reg_normalize), 32'd41);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_wr_ack", 32'(wr_ack), 32'd0);
    step();
    step();
    reset = 1'b0;
    repeat (2 * FRAME) step();
    chk("postrst_normalize", 32'(reg_normalize), 32'd41);

    // Random traffic with occasional resets.
    for (int i = 0; i < 6000; i++) begin
      step();
      wr_req = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 5))
        0:       wr_denominator = 8'd0;
        1:       wr_denominator = ($urandom_range(0, 1) == 0) ? 8'd32 : 8'd33;
        2:       wr_denominator = 8'd255;
        3:       wr_denominator = 8'(1 + $urandom_range(0, 2));
        default: wr_denominator = 8'($urandom_range(0, 255));
      endcase
`ifdef VDP_VIDEO_OUT_CTRL_SCANLINE_EN
      if ($urandom_range(0, 99) == 0) scanline_en = ~scanline_en;
`endif
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
      end
    end
    wr_req = 1'b0;
    repeat (2 * FRAME) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
